gearbox3to4: RTL and testbench
==============================

GEARBOX3TO4 -- requirements
Module: gearbox3to4

Interface
REQ-001 Parameter NGROUPS, default 2, number of independent 3-bit input / 4-bit output groups.
REQ-002 clk  input  1  single clock; all logic is in this domain.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_dat_i  input  NGROUPS*3  input beat, one group-phase of a 12*NGROUPS-bit word.
REQ-005 in_valid_i  input  1  beat on in_dat_i is valid.
REQ-006 in_sync_i  input  1  qualified by in_valid_i; marks the beat as input phase 0.
REQ-007 in_ready_o  output  1  block accepts the beat this cycle.
REQ-008 out_dat_o  output  NGROUPS*4  output word.
REQ-009 out_valid_o  output  1  out_dat_o is valid.
REQ-010 out_ready_i  input  1  downstream accepts out_dat_o.
REQ-011 out_phase_o  output  3  one-hot output phase of out_dat_o; valid with out_valid_o.
REQ-012 out_par_o  output  NGROUPS*12  assembled parallel word.
REQ-013 out_par_valid_o  output  1  one-cycle pulse marking a new out_par_o.
REQ-014 align_err_o  output  1  one-cycle pulse on an in_sync_i that breaks phase alignment.

Function
REQ-015 Accept = in_valid_i & in_ready_o; the input phase counter (0..3) advances on each accept and wraps 3->0.
REQ-016 Input phase k beat SHALL land in par[k*NGROUPS*3 +: NGROUPS*3]; output phase j SHALL carry par[j*NGROUPS*4 +: NGROUPS*4].
REQ-017 Accepting phase 0 produces no output; accepting phases 1, 2 and 3 loads output phases 0, 1 and 2 respectively.
REQ-018 out_valid_o SHALL assert the cycle after the loading accept, and out_phase_o SHALL be 001, 010 and 100 for output phases 0, 1 and 2.
REQ-019 out_dat_o and out_phase_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-020 in_ready_o = 1 when the input phase is 0; otherwise in_ready_o = !out_valid_o | out_ready_i (combinational, no skid buffer).
REQ-021 Full throughput: continuous valid and ready yield 3 output words per 4 input beats with no bubbles beyond the phase-0 slot.
REQ-022 An accepted beat with in_sync_i=1 SHALL be treated as phase 0 regardless of the counter.
REQ-023 If that counter was nonzero, align_err_o SHALL pulse the next cycle and the partial group is discarded, including any word not yet loaded to the output; words already output are unaffected.
REQ-024 in_sync_i on a phase-0 beat has no effect beyond normal operation; in_sync_i without in_valid_i is ignored.
REQ-025 out_par_o SHALL update on the phase-3 accept, with out_par_valid_o pulsing the following cycle.
REQ-026 The parallel path is not subject to out_ready_i backpressure.

Reset
REQ-027 While rst_n=0 at a clk edge, the input phase resets to 0 and out_valid_o, out_phase_o, out_dat_o, out_par_o, out_par_valid_o and align_err_o reset to 0.
REQ-028 Reset mid-group discards the partial group, and the first accept after reset is phase 0.
REQ-029 in_ready_o SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 Macro GEARBOX3TO4_PAR_EN defined: out_par_o and out_par_valid_o are generated per REQ-025 and REQ-026.
REQ-031 Macro GEARBOX3TO4_PAR_EN undefined: ports remain, out_par_o and out_par_valid_o are tied to 0, and no parallel register is built.

Structure
REQ-032 Shared package rackbus_pkg SHALL hold constants IN_PHASES=4, OUT_PHASES=3, IN_BITS=3 and OUT_BITS=4, plus a one-hot output-phase typedef.
REQ-033 Single module with no sub-module; the phase tracker stays inline.

Verification (NGROUPS=1)
REQ-034 Beats 000, 001, 010, 011 with sync on the first, ready high -> out_dat_o 8, 8, 6 with out_phase_o 001, 010, 100; out_par_o=0x688 with one out_par_valid_o pulse.
REQ-035 out_ready_i low after the first output word -> in_ready_o=0 on the phase-2 beat; out_dat_o held at 8 until out_ready_i rises, then the stream resumes with no loss.
REQ-036 Sync asserted on the third beat of a group -> align_err_o pulses once, no word is emitted for that beat, and the next group is decoded correctly.
REQ-037 rst_n low for one cycle after phase 2 -> all outputs 0 next cycle; the following 4 beats decode as a fresh group.
REQ-038 GEARBOX3TO4_PAR_EN undefined, stimulus as REQ-034 -> out_par_o stays 0, out_par_valid_o never pulses, and out_dat_o is identical to REQ-034.
REQ-039 1000 random beats with random valid/ready -> the output stream equals the input bit stream repacked, in order.

Source files
------------

// File: rtl/rackbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rackbus_pkg
// Purpose  : Shared constants and types for the 3-bit to 4-bit gearbox.
// Revision : 1.0 - initial release
// ============================================================================
package rackbus_pkg;

  localparam int IN_PHASES  = 4;  // input beats per parallel word
  localparam int OUT_PHASES = 3;  // output words per parallel word
  localparam int IN_BITS    = 3;  // bits per group on the input side
  localparam int OUT_BITS   = 4;  // bits per group on the output side

  // One-hot output phase; OPH_NONE is the idle/reset encoding.
  typedef enum logic [2:0] {
    OPH_NONE = 3'b000,
    OPH_0    = 3'b001,
    OPH_1    = 3'b010,
    OPH_2    = 3'b100
  } out_phase_t;

  // Accepting input phase k loads output phase k-1.
  function automatic out_phase_t out_phase_of(input logic [1:0] in_phase);
    case (in_phase)
      2'd1:    return OPH_0;
      2'd2:    return OPH_1;
      2'd3:    return OPH_2;
      default: return OPH_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/gearbox3to4.sv
`default_nettype none
// ============================================================================
// Module   : gearbox3to4
// Purpose  : Repacks four NGROUPS*3-bit input beats into three NGROUPS*4-bit
//            output words with ready/valid flow control, sync-based phase
//            alignment and an optional assembled parallel-word output.
// Config   : define GEARBOX3TO4_PAR_EN to build the out_par_o register;
//            otherwise out_par_o / out_par_valid_o are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module gearbox3to4
  import rackbus_pkg::*;
#(
  parameter int NGROUPS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NGROUPS*3-1:0]      in_dat_i,
  input  logic                      in_valid_i,
  input  logic                      in_sync_i,
  output logic                      in_ready_o,
  output logic [NGROUPS*4-1:0]      out_dat_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [2:0]                out_phase_o,
  output logic [NGROUPS*12-1:0]     out_par_o,
  output logic                      out_par_valid_o,
  output logic                      align_err_o
);

  localparam int IW = NGROUPS * IN_BITS;        // input beat width
  localparam int OW = NGROUPS * OUT_BITS;       // output word width
  localparam int PW = OUT_PHASES * OW;          // parallel word width
  localparam int AW = (IN_PHASES - 1) * IW;     // beats held before the last one
  localparam logic [1:0] LAST_PHASE = 2'(IN_PHASES - 1);

  logic [1:0]    phase_q;      // input phase of the next accepted beat
  logic [AW-1:0] acc_q;        // beats 0..2 of the current group
  logic          out_valid_q;
  logic [OW-1:0] out_dat_q;
  out_phase_t    out_phase_q;
  logic          align_err_q;

  logic          accept;
  logic [1:0]    eff_phase;    // sync forces the beat to phase 0
  logic          load;
  logic [1:0]    phase_d;
  logic [PW-1:0] par_d;        // stored beats with the current beat merged in
  logic [OW-1:0] word_d;

  // Phase 0 never loads the output, so it is always accepted.
  assign in_ready_o = (phase_q == 2'd0) | ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign eff_phase  = in_sync_i ? 2'd0 : phase_q;
  assign load       = accept & (eff_phase != 2'd0);
  assign phase_d    = eff_phase + 2'd1;

  // Merge the incoming beat into its slot of the parallel word.
  always_comb begin
    par_d = {in_dat_i, acc_q};
    case (eff_phase)
      2'd0:    par_d[0 +: IW]      = in_dat_i;
      2'd1:    par_d[IW +: IW]     = in_dat_i;
      2'd2:    par_d[2*IW +: IW]   = in_dat_i;
      default: par_d[3*IW +: IW]   = in_dat_i;
    endcase
  end

  // Select the output word completed by the beat in phase eff_phase.
  always_comb begin
    case (eff_phase)
      2'd1:    word_d = par_d[0 +: OW];
      2'd2:    word_d = par_d[OW +: OW];
      default: word_d = par_d[2*OW +: OW];
    endcase
  end

  // Phase tracking, beat storage and the registered output word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= 2'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      out_phase_q <= OPH_NONE;
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= accept & in_sync_i & (phase_q != 2'd0);
      if (accept) begin
        phase_q <= phase_d;
        acc_q   <= par_d[AW-1:0];
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_dat_q   <= word_d;
        out_phase_q <= out_phase_of(eff_phase);
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_dat_o   = out_dat_q;
  assign out_phase_o = out_phase_q;
  assign align_err_o = align_err_q;

`ifdef GEARBOX3TO4_PAR_EN
  logic [PW-1:0] par_q;
  logic          par_valid_q;

  // Capture the full word on the last-phase accept, free of output backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q       <= '0;
      par_valid_q <= 1'b0;
    end else begin
      par_valid_q <= accept & (eff_phase == LAST_PHASE);
      if (accept && (eff_phase == LAST_PHASE)) begin
        par_q <= par_d;
      end
    end
  end

  assign out_par_o       = par_q;
  assign out_par_valid_o = par_valid_q;
`else
  assign out_par_o       = '0;
  assign out_par_valid_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gearbox3to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_gearbox3to4
// Purpose  : Self-checking bench for gearbox3to4 with NGROUPS=1.
//            Honours GEARBOX3TO4_PAR_EN for the parallel-word expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gearbox3to4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_dat_i;
  logic        in_valid_i;
  logic        in_sync_i;
  logic        in_ready_o;
  logic [3:0]  out_dat_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  out_phase_o;
  logic [11:0] out_par_o;
  logic        out_par_valid_o;
  logic        align_err_o;

  int errors = 0;
  int checks = 0;

  gearbox3to4 #(.NGROUPS(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_dat_i        (in_dat_i),
    .in_valid_i      (in_valid_i),
    .in_sync_i       (in_sync_i),
    .in_ready_o      (in_ready_o),
    .out_dat_o       (out_dat_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_phase_o     (out_phase_o),
    .out_par_o       (out_par_o),
    .out_par_valid_o (out_par_valid_o),
    .align_err_o     (align_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [2:0]  dat;
    logic        valid;
    logic        sync;
    logic        ready;
    logic        e_ready;   // in_ready_o before the edge
    logic        e_valid;   // registered outputs after the edge
    logic [3:0]  e_dat;
    logic [2:0]  e_phase;
    logic        e_err;
    logic        e_pv;
    logic [11:0] e_par;
    logic        full;      // also check dat/phase while not valid
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic [2:0] d, input logic v, input logic s, input logic rd,
    input logic er, input logic ev, input logic [3:0] ed, input logic [2:0] ep,
    input logic ee, input logic epv, input logic [11:0] epar, input logic f);
    vec_t x;
    x.rst_n = r;  x.dat = d;  x.valid = v;  x.sync = s;  x.ready = rd;
    x.e_ready = er; x.e_valid = ev; x.e_dat = ed; x.e_phase = ep;
    x.e_err = ee; x.e_pv = epv; x.e_par = epar; x.full = f;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [11:0] par_exp;
    logic        pv_exp;
    bit          q[$];
    int          accepts;
    int          cyc;
    logic        acc;
    logic        hs;
    logic [3:0]  w;

    rst_n = 1'b0; in_dat_i = '0; in_valid_i = 1'b0; in_sync_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);

    //            rst dat    v  s  rdy | rdy v  dat   phase   err pv par     full
    // reset state and first cycle after reset
    vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 0, 4'h0, 3'b000, 0, 0, 12'h000, 1));
    vecs.push_back(mk(1, 3'b000, 0, 0, 0,  1, 0, 4'h0, 3'b000, 0, 0, 12'h000, 0));
    // basic group 000,001,010,011 with sync on the first beat
    vecs.push_back(mk(1, 3'b000, 1, 1, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h000, 0));
    vecs.push_back(mk(1, 3'b001, 1, 0, 1,  1, 1, 4'h8, 3'b001, 0, 0, 12'h000, 0));
    vecs.push_back(mk(1, 3'b010, 1, 0, 1,  1, 1, 4'h8, 3'b010, 0, 0, 12'h000, 0));
    vecs.push_back(mk(1, 3'b011, 1, 0, 1,  1, 1, 4'h6, 3'b100, 0, 1, 12'h688, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h688, 0));
    // backpressure after the first output word
    vecs.push_back(mk(1, 3'b000, 1, 0, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b001, 1, 0, 1,  1, 1, 4'h8, 3'b001, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b010, 1, 0, 0,  0, 1, 4'h8, 3'b001, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b010, 1, 0, 0,  0, 1, 4'h8, 3'b001, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b010, 1, 0, 1,  1, 1, 4'h8, 3'b010, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b011, 1, 0, 1,  1, 1, 4'h6, 3'b100, 0, 1, 12'h688, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 0,  1, 1, 4'h6, 3'b100, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h688, 0));
    // sync on the third beat of a group, then a clean group
    vecs.push_back(mk(1, 3'b101, 1, 1, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b110, 1, 0, 1,  1, 1, 4'h5, 3'b001, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b111, 1, 1, 1,  1, 0, 4'h0, 3'b000, 1, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b001, 1, 0, 1,  1, 1, 4'hF, 3'b001, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b101, 1, 0, 1,  1, 1, 4'h4, 3'b010, 0, 0, 12'h688, 0));
    vecs.push_back(mk(1, 3'b100, 1, 0, 1,  1, 1, 4'h9, 3'b100, 0, 1, 12'h94F, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h94F, 0));
    // reset after phase 2, then a fresh group without sync
    vecs.push_back(mk(1, 3'b000, 1, 1, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h94F, 0));
    vecs.push_back(mk(1, 3'b001, 1, 0, 1,  1, 1, 4'h8, 3'b001, 0, 0, 12'h94F, 0));
    vecs.push_back(mk(1, 3'b010, 1, 0, 1,  1, 1, 4'h8, 3'b010, 0, 0, 12'h94F, 0));
    vecs.push_back(mk(0, 3'b000, 1, 0, 0,  0, 0, 4'h0, 3'b000, 0, 0, 12'h000, 1));
    vecs.push_back(mk(1, 3'b001, 1, 0, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h000, 0));
    vecs.push_back(mk(1, 3'b011, 1, 0, 1,  1, 1, 4'h9, 3'b001, 0, 0, 12'h000, 0));
    vecs.push_back(mk(1, 3'b100, 1, 0, 1,  1, 1, 4'h1, 3'b010, 0, 0, 12'h000, 0));
    vecs.push_back(mk(1, 3'b010, 1, 0, 1,  1, 1, 4'h5, 3'b100, 0, 1, 12'h519, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 1,  1, 0, 4'h0, 3'b000, 0, 0, 12'h519, 0));

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      rst_n = v.rst_n; in_dat_i = v.dat; in_valid_i = v.valid;
      in_sync_i = v.sync; out_ready_i = v.ready;
      #1;
      check($sformatf("row%0d in_ready", i), 32'(in_ready_o), 32'(v.e_ready));
      @(posedge clk);
      #1;
`ifdef GEARBOX3TO4_PAR_EN
      par_exp = v.e_par;
      pv_exp  = v.e_pv;
`else
      par_exp = 12'h000;
      pv_exp  = 1'b0;
`endif
      check($sformatf("row%0d out_valid", i), 32'(out_valid_o), 32'(v.e_valid));
      check($sformatf("row%0d align_err", i), 32'(align_err_o), 32'(v.e_err));
      check($sformatf("row%0d par_valid", i), 32'(out_par_valid_o), 32'(pv_exp));
      check($sformatf("row%0d par", i), 32'(out_par_o), 32'(par_exp));
      if (v.e_valid || v.full) begin
        check($sformatf("row%0d out_dat", i), 32'(out_dat_o), 32'(v.e_dat));
        check($sformatf("row%0d out_phase", i), 32'(out_phase_o), 32'(v.e_phase));
      end
    end

    // Random stream: output words must be the accepted input bits repacked in order.
    accepts = 0;
    cyc = 0;
    while (accepts < 1000 && cyc < 20000) begin
      @(negedge clk);
      rst_n       = 1'b1;
      in_valid_i  = ($urandom_range(0, 3) != 0);
      in_dat_i    = 3'($urandom_range(0, 7));
      in_sync_i   = 1'b0;
      out_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid_i & in_ready_o;
      hs  = out_valid_o & out_ready_i;
      if (hs) begin
        if (q.size() < 4) begin
          checks++;
          errors++;
          $display("FAIL rand_underflow: got word 0x%0h with only %0d input bits pending", out_dat_o, q.size());
        end else begin
          for (int k = 0; k < 4; k++) w[k] = q.pop_front();
          check($sformatf("rand_word cyc%0d", cyc), 32'(out_dat_o), 32'(w));
        end
      end
      if (acc) begin
        for (int k = 0; k < 3; k++) q.push_back(in_dat_i[k]);
        accepts++;
      end
      @(posedge clk);
      cyc++;
    end
    if (accepts < 1000) begin
      checks++;
      errors++;
      $display("FAIL rand_accepts: got %0d accepted beats required 1000", accepts);
    end

    @(negedge clk);
    in_valid_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
